mdio_responder: RTL

Clause 22 MDIO management responder: the target-side counterpart of the MDC/MDIO manager that the Ethernet PCS/PMA path drives through its tristate I/O buffer. It oversamples MDC and MDIO in the system clock domain and decodes read and write frames addressed to its PHY address. It maps these frames onto a simple internal register port and drives read data back through `mdio_o`/`mdio_t`, which connect to an external IOBUF. It lets the microserver expose its own management registers on the same MDIO bus.

---
 rtl/mdio_pkg.sv | 25 ++
 rtl/mdio_responder_if.sv | 25 ++
 rtl/mdio_sync_edge.sv | 38 +++
 rtl/mdio_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause 22 MDIO responder.
// Frame field widths and opcodes live here so the FSM and any checkers agree on them.
package mdio_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ST    = 3'd1,
        OP    = 3'd2,
        PHYAD = 3'd3,
        REGAD = 3'd4,
        TA    = 3'd5,
        DATA  = 3'd6,
        SKIP  = 3'd7
    } mdio_state_e;

    localparam logic [1:0]  OP_READ   = 2'b10;
    localparam logic [1:0]  OP_WRITE  = 2'b01;
    localparam int unsigned TA_BITS   = 2;
    localparam int unsigned DATA_BITS = 16;

    function automatic logic is_valid_op(input logic [1:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/mdio_responder_if.sv
// MDIO pin pair plus the internal register port and status flags of the responder.
// The master modport is the manager/register-bank side, slave is the responder.
interface mdio_responder_if;
    logic        mdc;
    logic        mdio_i;
    logic        mdio_o;
    logic        mdio_t;
    logic [4:0]  reg_addr;
    logic        reg_rd_en;
    logic [15:0] reg_rd_data;
    logic        reg_wr_en;
    logic [15:0] reg_wr_data;
    logic        busy;
    logic        frame_err;

    modport master (
        output mdc, mdio_i, reg_rd_data,
        input  mdio_o, mdio_t, reg_addr, reg_rd_en, reg_wr_en, reg_wr_data, busy, frame_err
    );

    modport slave (
        input  mdc, mdio_i, reg_rd_data,
        output mdio_o, mdio_t, reg_addr, reg_rd_en, reg_wr_en, reg_wr_data, busy, frame_err
    );
endinterface

// File: rtl/mdio_sync_edge.sv
// Brings MDC/MDIO into the system clock domain and flags each MDC rising edge.
// The MDIO bit is registered alongside the tick so both refer to the same MDC edge.
module mdio_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic mdc,
    input  logic mdio_i,
    output logic tick,
    output logic mdio_bit
);

    logic [1:0] mdc_sync_r;
    logic [1:0] mdio_sync_r;
    logic       mdc_prev_r;
    logic       tick_r;
    logic       mdio_bit_r;

    // Synchronizers reset high so an idle-high MDC does not fake a rising edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            mdc_sync_r  <= 2'b11;
            mdio_sync_r <= 2'b11;
            mdc_prev_r  <= 1'b1;
            tick_r      <= 1'b0;
            mdio_bit_r  <= 1'b1;
        end else begin
            mdc_sync_r  <= {mdc_sync_r[0], mdc};
            mdio_sync_r <= {mdio_sync_r[0], mdio_i};
            mdc_prev_r  <= mdc_sync_r[1];
            tick_r      <= mdc_sync_r[1] & ~mdc_prev_r;
            mdio_bit_r  <= mdio_sync_r[1];
        end
    end

    assign tick     = tick_r;
    assign mdio_bit = mdio_bit_r;

endmodule

// File: rtl/mdio_responder.sv
// Clause 22 MDIO target: decodes frames for PHY_ADDR and maps them onto a simple
// register port, driving read data back through the tristate pair mdio_o/mdio_t.
module mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR     = 5'd1,
    parameter int unsigned PREAMBLE_MIN = 32
) (
    input  logic             clock,
    input  logic             reset,
    mdio_responder_if.slave  bus
);

    logic        tick_s;
    logic        bit_s;
    mdio_state_e state_r;
    logic [5:0]  pre_cnt_r;
    logic [3:0]  bit_cnt_r;
    logic [4:0]  skip_cnt_r;
    logic [1:0]  op_r;
    logic [15:0] shift_r;
    logic        latch_r;
    logic        mdio_o_r;
    logic        mdio_t_r;
    logic [4:0]  reg_addr_r;
    logic        reg_rd_en_r;
    logic        reg_wr_en_r;
    logic [15:0] reg_wr_data_r;
    logic        busy_r;
    logic        frame_err_r;

    mdio_sync_edge u_sync (
        .clock    (clock),
        .reset    (reset),
        .mdc      (bus.mdc),
        .mdio_i   (bus.mdio_i),
        .tick     (tick_s),
        .mdio_bit (bit_s)
    );

    // Frame decoder: all state advances on MDC ticks, strobes are single-cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= IDLE;
            pre_cnt_r     <= 6'd0;
            bit_cnt_r     <= 4'd0;
            skip_cnt_r    <= 5'd0;
            op_r          <= 2'b00;
            shift_r       <= 16'd0;
            latch_r       <= 1'b0;
            mdio_o_r      <= 1'b1;
            mdio_t_r      <= 1'b1;
            reg_addr_r    <= 5'd0;
            reg_rd_en_r   <= 1'b0;
            reg_wr_en_r   <= 1'b0;
            reg_wr_data_r <= 16'd0;
            busy_r        <= 1'b0;
            frame_err_r   <= 1'b0;
        end else begin
            reg_rd_en_r <= 1'b0;
            reg_wr_en_r <= 1'b0;
            frame_err_r <= 1'b0;
            latch_r     <= reg_rd_en_r;
            // Read data arrives the cycle after the strobe; no tick can land here.
            if (latch_r) begin
                shift_r <= bus.reg_rd_data;
            end
            if (tick_s) begin
                case (state_r)
                    IDLE: begin
                        if (bit_s) begin
                            if (pre_cnt_r != 6'd63) begin
                                pre_cnt_r <= pre_cnt_r + 6'd1;
                            end
                        end else begin
                            if (pre_cnt_r >= 6'(PREAMBLE_MIN)) begin
                                state_r <= ST;
                                busy_r  <= 1'b1;
                            end
                            pre_cnt_r <= 6'd0;
                        end
                    end
                    ST: begin
                        if (bit_s) begin
                            state_r   <= OP;
                            bit_cnt_r <= 4'd1;
                        end else begin
                            frame_err_r <= 1'b1;
                            busy_r      <= 1'b0;
                            state_r     <= IDLE;
                        end
                    end
                    OP: begin
                        op_r <= {op_r[0], bit_s};
                        if (bit_cnt_r != 4'd0) begin
                            bit_cnt_r <= bit_cnt_r - 4'd1;
                        end else if (is_valid_op({op_r[0], bit_s})) begin
                            state_r   <= PHYAD;
                            bit_cnt_r <= 4'd4;
                        end else begin
                            frame_err_r <= 1'b1;
                            busy_r      <= 1'b0;
                            state_r     <= IDLE;
                        end
                    end
                    PHYAD: begin
                        shift_r <= {shift_r[14:0], bit_s};
                        if (bit_cnt_r != 4'd0) begin
                            bit_cnt_r <= bit_cnt_r - 4'd1;
                        end else begin
                            state_r   <= REGAD;
                            bit_cnt_r <= 4'd4;
                        end
                    end
                    REGAD: begin
                        shift_r <= {shift_r[14:0], bit_s};
                        if (bit_cnt_r != 4'd0) begin
                            bit_cnt_r <= bit_cnt_r - 4'd1;
                        end else if (shift_r[8:4] == PHY_ADDR) begin
                            // PHYAD sits four bits up, REGAD[4:1] below it.
                            reg_addr_r  <= {shift_r[3:0], bit_s};
                            reg_rd_en_r <= (op_r == OP_READ);
                            state_r     <= TA;
                            bit_cnt_r   <= 4'(TA_BITS - 1);
                        end else begin
                            state_r    <= SKIP;
                            skip_cnt_r <= 5'(TA_BITS + DATA_BITS - 1);
                        end
                    end
                    TA: begin
                        if (bit_cnt_r != 4'd0) begin
                            bit_cnt_r <= bit_cnt_r - 4'd1;
                            if (op_r == OP_READ) begin
                                mdio_t_r <= 1'b0;
                                mdio_o_r <= 1'b0;
                            end
                        end else begin
                            state_r   <= DATA;
                            bit_cnt_r <= 4'(DATA_BITS - 1);
                            if (op_r == OP_READ) begin
                                mdio_o_r <= shift_r[15];
                                shift_r  <= {shift_r[14:0], 1'b0};
                            end
                        end
                    end
                    DATA: begin
                        if (op_r == OP_READ) begin
                            if (bit_cnt_r != 4'd0) begin
                                mdio_o_r <= shift_r[15];
                                shift_r  <= {shift_r[14:0], 1'b0};
                            end else begin
                                mdio_o_r <= 1'b1;
                                mdio_t_r <= 1'b1;
                            end
                        end else begin
                            shift_r <= {shift_r[14:0], bit_s};
                            if (bit_cnt_r == 4'd0) begin
                                reg_wr_data_r <= {shift_r[14:0], bit_s};
                                reg_wr_en_r   <= 1'b1;
                            end
                        end
                        if (bit_cnt_r != 4'd0) begin
                            bit_cnt_r <= bit_cnt_r - 4'd1;
                        end else begin
                            state_r   <= IDLE;
                            busy_r    <= 1'b0;
                            pre_cnt_r <= 6'd0;
                        end
                    end
                    SKIP: begin
                        if (skip_cnt_r != 5'd0) begin
                            skip_cnt_r <= skip_cnt_r - 5'd1;
                        end else begin
                            state_r   <= IDLE;
                            busy_r    <= 1'b0;
                            pre_cnt_r <= 6'd0;
                        end
                    end
                    default: begin
                        state_r  <= IDLE;
                        busy_r   <= 1'b0;
                        mdio_t_r <= 1'b1;
                        mdio_o_r <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.mdio_o      = mdio_o_r;
    assign bus.mdio_t      = mdio_t_r;
    assign bus.reg_addr    = reg_addr_r;
    assign bus.reg_rd_en   = reg_rd_en_r;
    assign bus.reg_wr_en   = reg_wr_en_r;
    assign bus.reg_wr_data = reg_wr_data_r;
    assign bus.busy        = busy_r;
    assign bus.frame_err   = frame_err_r;

endmodule
